// File: rtl/handshake_constant_stream.sv
// Arithmetic-sequence token source: each accepted control token emits base + k*STEP,
// optionally wrapping to base every WRAP_COUNT tokens, buffered by a 2-entry elastic FIFO.
module handshake_constant_stream #(
    parameter int unsigned                DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0]      CONST_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0]      STEP        = '0,
    parameter int unsigned                WRAP_COUNT  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    input  logic                  cfg_valid,
    input  logic [DATA_WIDTH-1:0] cfg_value,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int unsigned IDX_W = (WRAP_COUNT > 1) ? $clog2(WRAP_COUNT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = (WRAP_COUNT == 0) ? '0 : IDX_W'(WRAP_COUNT - 1);

    logic [DATA_WIDTH-1:0] r_base;
    logic [DATA_WIDTH-1:0] r_cur;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_rdPtr;
    logic                  r_wrPtr;
    logic [1:0]            r_count;

    logic w_accept;
    logic w_pop;
    logic w_wrapNow;

    // Ready depends only on registered occupancy, never on outs_ready.
    assign ctrl_ready = rst & (r_count != 2'd2);
    assign outs_valid = (r_count != 2'd0);
    assign outs       = r_mem[r_rdPtr];

    assign w_accept  = ctrl_valid & ctrl_ready;
    assign w_pop     = outs_valid & outs_ready;
    assign w_wrapNow = (WRAP_COUNT != 0) && (r_idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base   <= CONST_VALUE;
            r_cur    <= CONST_VALUE;
            r_idx    <= '0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rdPtr  <= 1'b0;
            r_wrPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_accept) begin
                r_mem[r_wrPtr] <= r_cur;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            // A config load wins over sequencing; a token pushed this cycle still carries the old cur.
            if (cfg_valid) begin
                r_base <= cfg_value;
                r_cur  <= cfg_value;
                r_idx  <= '0;
            end else if (w_accept) begin
                if (w_wrapNow) begin
                    r_cur <= r_base;
                    r_idx <= '0;
                end else begin
                    r_cur <= r_cur + STEP;
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_handshake_constant_stream.sv
// Bench for handshake_constant_stream: four parameterisations run side by side, checked by a
// queue scoreboard every cycle plus a vector table and hand-written corner sequences.
module tb_handshake_constant_stream;

    localparam int NDUT = 4;
    // Instance 0: defaults, 1: 10/+3/wrap 4, 2: near-rollover/+1, 3: 0/+1 (config tests)
    localparam logic [3:0][31:0] P_CONST = {32'd0, 32'hFFFF_FFFE, 32'd10, 32'd0};
    localparam logic [3:0][31:0] P_STEP  = {32'd1, 32'd1,         32'd3,  32'd0};
    localparam logic [3:0][31:0] P_WRAP  = {32'd0, 32'd0,         32'd4,  32'd0};

    logic        clk;
    logic        rst;
    logic        ctrlValid [NDUT];
    logic        ctrlReady [NDUT];
    logic        cfgValid  [NDUT];
    logic [31:0] cfgValue  [NDUT];
    logic [31:0] outs      [NDUT];
    logic        outsValid [NDUT];
    logic        outsReady [NDUT];

    int checkCount = 0;
    int passCount  = 0;

    int          mCount [NDUT];
    logic [31:0] mBase  [NDUT];
    logic [31:0] mCur   [NDUT];
    int          mIdx   [NDUT];
    logic [31:0] sbQ    [NDUT][$];

    typedef struct {
        logic        cv;
        logic        orr;
        logic        cfgv;
        logic [31:0] cfgVal;
        logic        expReady;
        logic        expValid;
        logic        chkOuts;
        logic [31:0] expOuts;
    } vecT;

    vecT vecs [12];

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        handshake_constant_stream #(
            .DATA_WIDTH  (32),
            .CONST_VALUE (P_CONST[g]),
            .STEP        (P_STEP[g]),
            .WRAP_COUNT  (int'(P_WRAP[g]))
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .ctrl_valid (ctrlValid[g]),
            .ctrl_ready (ctrlReady[g]),
            .cfg_valid  (cfgValid[g]),
            .cfg_value  (cfgValue[g]),
            .outs       (outs[g]),
            .outs_valid (outsValid[g]),
            .outs_ready (outsReady[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input int k, input logic cv, input logic orr,
                                 input logic cfgv, input logic [31:0] cfgVal);
        ctrlValid[k] = cv;
        outsReady[k] = orr;
        cfgValid[k]  = cfgv;
        cfgValue[k]  = cfgVal;
    endtask

    // Reference model: predicts handshake state and the value queue for the next edge.
    task automatic scoreboardStep();
        logic acc;
        logic pop;
        for (int k = 0; k < NDUT; k++) begin
            if (!rst) begin
                checkOutput($sformatf("rstValid%0d", k), 32'(outsValid[k]), 32'd0);
                checkOutput($sformatf("rstReady%0d", k), 32'(ctrlReady[k]), 32'd0);
                checkOutput($sformatf("rstOuts%0d", k), outs[k], 32'd0);
                mCount[k] = 0;
                sbQ[k].delete();
                mBase[k] = P_CONST[k];
                mCur[k]  = P_CONST[k];
                mIdx[k]  = 0;
            end else begin
                checkOutput($sformatf("sbReady%0d", k), 32'(ctrlReady[k]), 32'(mCount[k] != 2));
                checkOutput($sformatf("sbValid%0d", k), 32'(outsValid[k]), 32'(mCount[k] != 0));
                if (mCount[k] != 0 && sbQ[k].size() > 0)
                    checkOutput($sformatf("sbOuts%0d", k), outs[k], sbQ[k][0]);
                acc = ctrlValid[k] && (mCount[k] != 2);
                pop = outsReady[k] && (mCount[k] != 0);
                if (pop && sbQ[k].size() > 0) void'(sbQ[k].pop_front());
                if (acc) begin
                    sbQ[k].push_back(mCur[k]);
                    if (P_WRAP[k] != 0 && mIdx[k] == int'(P_WRAP[k]) - 1) begin
                        mCur[k] = mBase[k];
                        mIdx[k] = 0;
                    end else begin
                        mCur[k] = mCur[k] + P_STEP[k];
                        mIdx[k] = mIdx[k] + 1;
                    end
                end
                if (cfgValid[k]) begin
                    mBase[k] = cfgValue[k];
                    mCur[k]  = cfgValue[k];
                    mIdx[k]  = 0;
                end
                mCount[k] = mCount[k] + (acc ? 1 : 0) - (pop ? 1 : 0);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            scoreboardStep();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] seq1 [10];
        logic [31:0] seq2 [4];
        logic        bpReady [4];
        logic [31:0] held;
        int n1;
        int n2;

        seq1 = '{32'd10, 32'd13, 32'd16, 32'd19, 32'd10, 32'd13, 32'd16, 32'd19, 32'd10, 32'd13};
        seq2 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        bpReady = '{1'b1, 1'b1, 1'b0, 1'b0};

        //            cv    orr   cfgv  cfgVal   rdy   vld   chk   outs
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd0,   1'b1, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'd100, 1'b1, 1'b1, 1'b1, 32'd1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd2};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd100};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd101};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd0,   1'b1, 1'b0, 1'b0, 32'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'd200, 1'b1, 1'b1, 1'b1, 32'd102};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd102};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'd0,   1'b1, 1'b0, 1'b0, 32'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'd0,   1'b1, 1'b1, 1'b1, 32'd200};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'd0,   1'b1, 1'b0, 1'b0, 32'd0};

        rst = 1'b0;
        for (int k = 0; k < NDUT; k++) applyStimulus(k, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Streaming, wrap, rollover and config-with-accept all in one pass
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #2;
            applyStimulus(3, vecs[i].cv, vecs[i].orr, vecs[i].cfgv, vecs[i].cfgVal);
            for (int k = 0; k < 3; k++) applyStimulus(k, 1'b1, 1'b1, 1'b0, 32'd0);
            @(negedge clk);
            checkOutput($sformatf("vecReady[%0d]", i), 32'(ctrlReady[3]), 32'(vecs[i].expReady));
            checkOutput($sformatf("vecValid[%0d]", i), 32'(outsValid[3]), 32'(vecs[i].expValid));
            if (vecs[i].chkOuts)
                checkOutput($sformatf("vecOuts[%0d]", i), outs[3], vecs[i].expOuts);
            checkOutput($sformatf("constOuts[%0d]", i), outs[0], 32'd0);
            checkOutput($sformatf("constReady[%0d]", i), 32'(ctrlReady[0]), 32'd1);
            if (outsValid[1] && n1 < 10) begin
                checkOutput($sformatf("wrapSeq[%0d]", n1), outs[1], seq1[n1]);
                n1++;
            end
            if (outsValid[2] && n2 < 4) begin
                checkOutput($sformatf("rollSeq[%0d]", n2), outs[2], seq2[n2]);
                n2++;
            end
        end
        checkOutput("wrapSeqCount", 32'(n1), 32'd10);
        checkOutput("rollSeqCount", 32'(n2), 32'd4);

        // Drain everything, then backpressure on instance 2
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #2;
            for (int k = 0; k < NDUT; k++) applyStimulus(k, 1'b0, 1'b1, 1'b0, 32'd0);
        end
        held = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #2 applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'd0);
            @(negedge clk);
            checkOutput($sformatf("bpReady[%0d]", c), 32'(ctrlReady[2]), 32'(bpReady[c]));
            if (c == 1) held = outs[2];
            if (c > 1) checkOutput($sformatf("bpStable[%0d]", c), outs[2], held);
        end
        @(posedge clk);
        #2 applyStimulus(2, 1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("bpPopCycleReady", 32'(ctrlReady[2]), 32'd0);
        @(posedge clk);
        #2 applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("bpReadyReturn", 32'(ctrlReady[2]), 32'd1);
        checkOutput("bpStillValid", 32'(outsValid[2]), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2 applyStimulus(2, 1'b0, 1'b1, 1'b0, 32'd0);
        end

        // Fill instance 1 then reset mid-cycle
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2 applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'd0);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(outsValid[1]), 32'd0);
        checkOutput("midRstReady", 32'(ctrlReady[1]), 32'd0);
        checkOutput("midRstOuts", outs[1], 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("postRstEmpty", 32'(outsValid[1]), 32'd0);
        @(negedge clk);
        checkOutput("postRstFirst", outs[1], 32'd10);
        @(negedge clk);
        checkOutput("postRstSecond", outs[1], 32'd13);
        @(posedge clk);
        #2 applyStimulus(1, 1'b0, 1'b1, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
